// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if: request and SPI pin bundle for spi_frame_ctrl.
//   data_in   frame word, sampled when a start is accepted
//   start_in  start request
//   busy_out  frame in progress
//   done_out  one-cycle completion pulse
//   sclk_out  serial clock (mode 0, idles low)
//   mosi_out  serial data, MSB first
//   cs_n_out  active-low chip select
// slave is the frame controller; master is the word producer / observer.
interface spi_frame_ctrl_if #(
  parameter int unsigned SIZE = 8
);
  logic [SIZE-1:0] data_in;
  logic            start_in;
  logic            busy_out;
  logic            done_out;
  logic            sclk_out;
  logic            mosi_out;
  logic            cs_n_out;

  modport master (
    output data_in, start_in,
    input  busy_out, done_out, sclk_out, mosi_out, cs_n_out
  );

  modport slave (
    input  data_in, start_in,
    output busy_out, done_out, sclk_out, mosi_out, cs_n_out
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl: sequences one SPI write frame (mode 0, MSB first) for the
// stepper driver chips. A start in IDLE latches data_in, asserts chip select,
// waits CS_SETUP clocks, emits SIZE serial clocks of 2*CLK_DIV system clocks
// each, holds chip select for CS_HOLD clocks and pulses done_out.
// Ports:
//   clk_in    system clock, rising edge
//   reset_in  synchronous active-high reset; aborts any frame without done_out
//   bus       spi_frame_ctrl_if slave modport (request + SPI pins)
module spi_frame_ctrl #(
  parameter int unsigned SIZE     = 8,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CS_SETUP = 2,
  parameter int unsigned CS_HOLD  = 2
) (
  input logic              clk_in,
  input logic              reset_in,
  spi_frame_ctrl_if.slave  bus
);

  localparam int unsigned MaxA     = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned PhaseMax = (MaxA > CS_HOLD) ? MaxA : CS_HOLD;
  localparam int unsigned PhaseW   = $clog2(PhaseMax + 1);
  localparam int unsigned BitW     = $clog2(SIZE);

  // Phase counter counts down to zero, so each load is the duration minus one.
  localparam logic [PhaseW-1:0] SetupLoad = PhaseW'(CS_SETUP - 1);
  localparam logic [PhaseW-1:0] DivLoad   = PhaseW'(CLK_DIV - 1);
  localparam logic [PhaseW-1:0] HoldLoad  = PhaseW'(CS_HOLD - 1);
  localparam logic [BitW-1:0]   LastBit   = BitW'(SIZE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StLow,
    StHigh,
    StHold
  } state_e;

  state_e            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [SIZE-1:0]   shreg_q, shreg_d;
  logic              done_q, done_d;

  // State and datapath registers.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_in) begin
          state_d = StSetup;
          shreg_d = bus.data_in;
          phase_d = SetupLoad;
          bit_d   = '0;
        end
      end
      StSetup: begin
        if (phase_q == '0) begin
          state_d = StLow;
          phase_d = DivLoad;
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      StLow: begin
        if (phase_q == '0) begin
          state_d = StHigh;
          phase_d = DivLoad;
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      StHigh: begin
        if (phase_q == '0) begin
          if (bit_q == LastBit) begin
            state_d = StHold;
            phase_d = HoldLoad;
          end else begin
            // Shifting on the falling edge keeps mosi stable across the next rise.
            state_d = StLow;
            phase_d = DivLoad;
            shreg_d = {shreg_q[SIZE-2:0], 1'b0};
            bit_d   = bit_q + BitW'(1);
          end
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      StHold: begin
        if (phase_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          phase_d = phase_q - PhaseW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode purely from registered state, so they change one clock after the event.
  always_comb begin
    bus.cs_n_out = 1'b1;
    bus.sclk_out = 1'b0;
    bus.mosi_out = 1'b0;
    bus.busy_out = 1'b0;
    bus.done_out = done_q;
    unique case (state_q)
      StIdle: begin
        bus.cs_n_out = 1'b1;
      end
      StSetup, StLow, StHold: begin
        bus.cs_n_out = 1'b0;
        bus.mosi_out = shreg_q[SIZE-1];
        bus.busy_out = 1'b1;
      end
      StHigh: begin
        bus.cs_n_out = 1'b0;
        bus.sclk_out = 1'b1;
        bus.mosi_out = shreg_q[SIZE-1];
        bus.busy_out = 1'b1;
      end
      default: begin
        bus.cs_n_out = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl: directed bench for spi_frame_ctrl. One instance uses the
// default parameters; a second uses SIZE=40, CLK_DIV=1, CS_SETUP=1, CS_HOLD=1.
// Negedge monitors tally SCLK rises, the MOSI bits seen at each rise, and
// cycles with chip select low, busy high and done high.
module tb_spi_frame_ctrl;

  logic clk;
  logic reset;
  int   cyc;

  spi_frame_ctrl_if #(.SIZE(8))  bus8 ();
  spi_frame_ctrl_if #(.SIZE(40)) bus40 ();

  spi_frame_ctrl #(
    .SIZE(8), .CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)
  ) u_dut8 (
    .clk_in  (clk),
    .reset_in(reset),
    .bus     (bus8)
  );

  spi_frame_ctrl #(
    .SIZE(40), .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1)
  ) u_dut40 (
    .clk_in  (clk),
    .reset_in(reset),
    .bus     (bus40)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitors for the 8-bit instance.
  logic        prev8 = 1'b0;
  int          rises8 = 0;
  logic [63:0] bits8 = '0;
  int          cslow8 = 0;
  int          busy8 = 0;
  int          dones8 = 0;
  always @(negedge clk) begin
    if (bus8.sclk_out === 1'b1 && prev8 === 1'b0) begin
      rises8 <= rises8 + 1;
      bits8  <= {bits8[62:0], bus8.mosi_out};
    end
    prev8 <= bus8.sclk_out;
    if (bus8.cs_n_out === 1'b0) cslow8 <= cslow8 + 1;
    if (bus8.busy_out === 1'b1) busy8 <= busy8 + 1;
    if (bus8.done_out === 1'b1) dones8 <= dones8 + 1;
  end

  // Monitors for the 40-bit instance.
  logic        prev40 = 1'b0;
  int          rises40 = 0;
  logic [63:0] bits40 = '0;
  int          busy40 = 0;
  always @(negedge clk) begin
    if (bus40.sclk_out === 1'b1 && prev40 === 1'b0) begin
      rises40 <= rises40 + 1;
      bits40  <= {bits40[62:0], bus40.mosi_out};
    end
    prev40 <= bus40.sclk_out;
    if (bus40.busy_out === 1'b1) busy40 <= busy40 + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Snapshot of the 8-bit pins: {cs_n, sclk, mosi, busy, done}.
  function automatic logic [4:0] pins8();
    return {bus8.cs_n_out, bus8.sclk_out, bus8.mosi_out, bus8.busy_out, bus8.done_out};
  endfunction

  // Waits (bounded) for done_out; returns the cycle stamp, or -1 on timeout.
  task automatic wait_done(input bit big, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((big ? bus40.done_out : bus8.done_out) === 1'b1) begin
        at = cyc;
        break;
      end
    end
  endtask

  // Presents one start on the 8-bit instance; t0 is the accepting edge's stamp.
  task automatic start8(input logic [7:0] d, output int t0);
    bus8.data_in  = d;
    bus8.start_in = 1'b1;
    @(negedge clk);
    bus8.start_in = 1'b0;
    t0 = cyc;
  endtask

  initial begin
    int t0, at, at2;
    int r0, c0, b0, d0;

    reset          = 1'b1;
    bus8.start_in  = 1'b1;
    bus8.data_in   = 8'hAC;
    bus40.start_in = 1'b0;
    bus40.data_in  = '0;

    // Reset dominates a held start.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_pins", 64'(pins8()), 64'(5'b10000));
    end
    reset         = 1'b0;
    bus8.start_in = 1'b0;
    repeat (2) @(negedge clk);

    // Single frame, 8'b10101100.
    r0 = rises8; c0 = cslow8; b0 = busy8; d0 = dones8;
    start8(8'hAC, t0);
    check("t0_pins", 64'(pins8()), 64'(5'b00110));
    wait_done(1'b0, 100, at);
    check("single_done_time", 64'(at), 64'(t0 + 68));
    @(negedge clk);
    check("single_done_pulse", 64'(bus8.done_out), 64'(1'b0));
    check("single_rises", 64'(rises8 - r0), 64'd8);
    check("single_bits", 64'(bits8[7:0]), 64'h00AC);
    check("single_cs_low", 64'(cslow8 - c0), 64'd68);
    check("single_busy", 64'(busy8 - b0), 64'd68);
    check("single_dones", 64'(dones8 - d0), 64'd1);

    // Start while busy is ignored.
    repeat (3) @(negedge clk);
    r0 = rises8; d0 = dones8;
    start8(8'hAC, t0);
    repeat (9) @(negedge clk);
    bus8.data_in  = 8'hFF;
    bus8.start_in = 1'b1;
    @(negedge clk);
    bus8.start_in = 1'b0;
    wait_done(1'b0, 100, at);
    check("busy_done_time", 64'(at), 64'(t0 + 68));
    repeat (80) @(negedge clk);
    check("busy_rises", 64'(rises8 - r0), 64'd8);
    check("busy_bits", 64'(bits8[7:0]), 64'h00AC);
    check("busy_dones", 64'(dones8 - d0), 64'd1);
    check("busy_idle_after", 64'(pins8()), 64'(5'b10000));

    // Back-to-back frames with start held.
    r0 = rises8;
    bus8.data_in  = 8'h3C;
    bus8.start_in = 1'b1;
    @(negedge clk);
    t0 = cyc;
    wait_done(1'b0, 100, at);
    check("b2b_done1_time", 64'(at), 64'(t0 + 68));
    check("b2b_gap_cs_high", 64'(bus8.cs_n_out), 64'(1'b1));
    @(negedge clk);
    check("b2b_second_cs_low", 64'(bus8.cs_n_out), 64'(1'b0));
    wait_done(1'b0, 100, at2);
    bus8.start_in = 1'b0;
    check("b2b_done_gap", 64'(at2 - at), 64'd69);
    repeat (2) @(negedge clk);
    check("b2b_rises", 64'(rises8 - r0), 64'd16);
    check("b2b_bits", 64'(bits8[15:0]), 64'h3C3C);
    check("b2b_stopped", 64'(bus8.busy_out), 64'(1'b0));

    // Mid-frame reset at T0+30.
    repeat (3) @(negedge clk);
    d0 = dones8;
    start8(8'h5A, t0);
    repeat (29) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_pins", 64'(pins8()), 64'(5'b10000));
    repeat (80) @(negedge clk);
    check("abort_no_done", 64'(dones8 - d0), 64'd0);
    r0 = rises8;
    start8(8'h81, t0);
    wait_done(1'b0, 100, at);
    check("after_abort_done_time", 64'(at), 64'(t0 + 68));
    @(negedge clk);
    check("after_abort_rises", 64'(rises8 - r0), 64'd8);
    check("after_abort_bits", 64'(bits8[7:0]), 64'h0081);

    // 40-bit variant: 1 + 2*1*40 + 1 = 82 cycles.
    r0 = rises40; b0 = busy40;
    bus40.data_in  = 40'hA5000000FF;
    bus40.start_in = 1'b1;
    @(negedge clk);
    bus40.start_in = 1'b0;
    t0 = cyc;
    check("wide_t0_mosi", 64'(bus40.mosi_out), 64'(1'b1));
    wait_done(1'b1, 200, at);
    check("wide_done_time", 64'(at), 64'(t0 + 82));
    @(negedge clk);
    check("wide_rises", 64'(rises40 - r0), 64'd40);
    check("wide_bits", 64'(bits40[39:0]), 64'h00A5000000FF);
    check("wide_busy", 64'(busy40 - b0), 64'd82);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
